// File: rtl/dsp_lowp_tdm_pkg.sv
// Shared definitions for the time-multiplexed lowpass: fixed-point format,
// FSM state encoding and the coefficient clamp.
package dsp_lowp_tdm_pkg;

    localparam int DSP_W     = 16;
    localparam int FRAC_BITS = 14;
    localparam int FP_ONE    = 1 << FRAC_BITS;

    typedef enum logic [1:0] {
        IDLE,
        MUL_A,
        MUL_B,
        PUBLISH
    } fsm_state_e;

    // Keep the coefficient inside [0, 1.0] so the filter stays stable.
    function automatic int clamp_coef(input int c);
        if (c < 0)
            return 0;
        else if (c > FP_ONE)
            return FP_ONE;
        else
            return c;
    endfunction

endpackage

// File: rtl/dsp_mult.sv
// Combinational signed fixed-point multiplier: full product scaled back by
// FRAC bits and wrapped to W bits.
module dsp_mult #(
    parameter int W    = 16,
    parameter int FRAC = 14
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] p_o
);

    logic signed [2*W-1:0] prod_full;

    assign prod_full = a_i * b_i;
    assign p_o       = W'(prod_full >>> FRAC);

endmodule

// File: rtl/dsp_lowp_tdm.sv
// One-pole lowpass for NCH voices, sequenced through a single shared
// multiplier: y = x*c + y_prev*(1-c), published as one coherent frame.
module dsp_lowp_tdm
    import dsp_lowp_tdm_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = DSP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sampleTick,
    input  logic [NCH*W-1:0] sigIn,
    input  logic [NCH*W-1:0] cutoff,
    output logic [NCH*W-1:0] sigOut,
    output logic             done,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef logic signed [W-1:0] sample_t;

    fsm_state_e       state_q, state_d;
    logic [CW-1:0]    ch_q, ch_d;
    sample_t          acc_q, acc_d;

    sample_t          x_snap_q [NCH];
    sample_t          c_q      [NCH];
    sample_t          invc_q   [NCH];
    sample_t          y_q      [NCH];
    sample_t          c_clamp  [NCH];

    logic [NCH*W-1:0] sig_out_q;
    logic             done_q, busy_q, overrun_q;

    sample_t          mul_a, mul_b, prod;
    logic             last_ch;

    assign last_ch = (ch_q == CW'(NCH - 1));

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            c_clamp[i] = sample_t'(clamp_coef(int'($signed(cutoff[i*W +: W]))));
        end
    end

    // Operands come only from snapshot/state registers, never from the ports.
    always_comb begin
        mul_a = x_snap_q[ch_q];
        mul_b = c_q[ch_q];
        if (state_q == MUL_B) begin
            mul_a = y_q[ch_q];
            mul_b = invc_q[ch_q];
        end
    end

    dsp_mult #(
        .W    (W),
        .FRAC (FRAC_BITS)
    ) u_mult (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (prod)
    );

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (sampleTick) begin
                    state_d = MUL_A;
                    ch_d    = '0;
                end
            end
            MUL_A: begin
                acc_d   = prod;
                state_d = MUL_B;
            end
            MUL_B: begin
                if (last_ch) begin
                    state_d = PUBLISH;
                end else begin
                    ch_d    = ch_q + CW'(1);
                    state_d = MUL_A;
                end
            end
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            acc_q   <= acc_d;
        end
    end

    // NOTE: the small per-channel arrays are register files, so they are reset
    // explicitly; a discarded frame must leave no filter history behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                x_snap_q[i] <= '0;
                c_q[i]      <= '0;
                invc_q[i]   <= '0;
                y_q[i]      <= '0;
            end
            sig_out_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            overrun_q <= sampleTick && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (sampleTick) begin
                        busy_q <= 1'b1;
                        for (int i = 0; i < NCH; i++) begin
                            x_snap_q[i] <= sigIn[i*W +: W];
                            c_q[i]      <= c_clamp[i];
                            invc_q[i]   <= sample_t'(FP_ONE) - c_clamp[i];
                        end
                    end
                end
                MUL_B: y_q[ch_q] <= acc_q + prod;
                PUBLISH: begin
                    for (int i = 0; i < NCH; i++) begin
                        sig_out_q[i*W +: W] <= y_q[i];
                    end
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign sigOut  = sig_out_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_dsp_lowp_tdm.sv
// Directed bench for dsp_lowp_tdm (NCH=4, Q2.14): table of frames plus
// hand-written overrun, snapshot, back-to-back and reset sequences.
module tb_dsp_lowp_tdm;

    localparam int NCH = 4;
    localparam int W   = 16;
    localparam int ONE = 16384;
    localparam int H   = 8192;
    localparam int Q   = 4096;
    localparam int LAT = 2 * NCH + 1;

    typedef struct {
        logic [NCH*W-1:0] x;
        logic [NCH*W-1:0] c;
        logic [NCH*W-1:0] y;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sampleTick = 1'b0;
    logic [NCH*W-1:0] sigIn = '0;
    logic [NCH*W-1:0] cutoff = '0;
    logic [NCH*W-1:0] sigOut;
    logic             done, busy, overrun;

    int tests_run = 0;
    int tests_failed = 0;

    dsp_lowp_tdm #(.NCH(NCH), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sampleTick (sampleTick),
        .sigIn      (sigIn),
        .cutoff     (cutoff),
        .sigOut     (sigOut),
        .done       (done),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [NCH*W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts a frame and waits (bounded) for done, recording timing and overruns.
    task automatic run_frame(input logic [NCH*W-1:0] x, input logic [NCH*W-1:0] c,
                             input bit immediate, input int extra_at, input int change_at,
                             output int lat, output int ovr_at, output int ovr_cnt,
                             output int busy_low);
        sigIn  = x;
        cutoff = c;
        if (!immediate) begin
            @(posedge clk); #1;
        end
        sampleTick = 1'b1;
        @(posedge clk); #1;
        sampleTick = 1'b0;
        lat = -1; ovr_at = -1; ovr_cnt = 0; busy_low = 0;
        for (int k = 1; k <= 30; k++) begin
            sampleTick = (k == extra_at);
            if (k == change_at) begin
                sigIn  = ~x;
                cutoff = '0;
            end
            @(posedge clk); #1;
            if (overrun) begin
                ovr_cnt++;
                if (ovr_at < 0) ovr_at = k;
            end
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_low++;
        end
        sampleTick = 1'b0;
    endtask

    vec_t vecs[4];
    int lat, ovr_at, ovr_cnt, busy_low, extra_done;

    initial begin
        vecs[0] = '{x: pack4(H, H, H, -H),  c: pack4(ONE, H, -Q, ONE + H), y: pack4(H, Q, 0, -H)};
        vecs[1] = '{x: pack4(H, H, H, -H),  c: pack4(ONE, H, -Q, ONE + H), y: pack4(H, 6144, 0, -H)};
        vecs[2] = '{x: pack4(H, H, H, -H),  c: pack4(ONE, H, -Q, ONE + H), y: pack4(H, 7168, 0, -H)};
        vecs[3] = '{x: pack4(Q, -Q, H, H),  c: pack4(0, ONE, H, Q),        y: pack4(H, -Q, Q, -Q)};

        repeat (3) @(posedge clk);
        #1;
        check("reset_sigOut", 64'(sigOut), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_overrun", 64'(overrun), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].x, vecs[i].c, 1'b0, 0, 0, lat, ovr_at, ovr_cnt, busy_low);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
            check($sformatf("vec%0d_sigOut", i), 64'(sigOut), 64'(vecs[i].y));
            check($sformatf("vec%0d_busy_gaps", i), 64'(busy_low), 64'(0));
            check($sformatf("vec%0d_busy_at_done", i), 64'(busy), 64'(0));
            check($sformatf("vec%0d_overrun", i), 64'(ovr_cnt), 64'(0));
        end

        // Second tick three clocks into the frame is dropped with one overrun pulse.
        run_frame(pack4(0, 0, 0, 0), pack4(H, H, H, H), 1'b0, 3, 0, lat, ovr_at, ovr_cnt, busy_low);
        check("ovr_latency", 64'(lat), 64'(LAT));
        check("ovr_pulse_cycle", 64'(ovr_at), 64'(3));
        check("ovr_pulse_count", 64'(ovr_cnt), 64'(1));
        check("ovr_sigOut", 64'(sigOut), 64'(pack4(Q, -2048, 2048, -2048)));
        extra_done = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done) extra_done++;
        end
        check("ovr_no_extra_frame", 64'(extra_done), 64'(0));

        // Port changes mid-frame must not reach the arithmetic.
        run_frame(pack4(H, H, H, H), pack4(ONE, ONE, ONE, ONE), 1'b0, 0, 4, lat, ovr_at, ovr_cnt, busy_low);
        check("snap_latency", 64'(lat), 64'(LAT));
        check("snap_sigOut", 64'(sigOut), 64'(pack4(H, H, H, H)));

        // Tick in the done cycle is accepted without overrun.
        run_frame(pack4(-H, -H, -H, -H), pack4(Q, Q, Q, Q), 1'b1, 0, 0, lat, ovr_at, ovr_cnt, busy_low);
        check("b2b_latency", 64'(lat), 64'(LAT));
        check("b2b_overrun", 64'(ovr_cnt), 64'(0));
        check("b2b_sigOut", 64'(sigOut), 64'(pack4(Q, Q, Q, Q)));

        // Reset five clocks into a frame discards it and clears history.
        sigIn  = pack4(H, H, H, H);
        cutoff = pack4(H, H, H, H);
        @(posedge clk); #1;
        sampleTick = 1'b1;
        @(posedge clk); #1;
        sampleTick = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("rst_sigOut", 64'(sigOut), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        extra_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) extra_done++;
        end
        check("rst_no_done", 64'(extra_done), 64'(0));
        check("rst_sigOut_held", 64'(sigOut), 64'(0));

        run_frame(vecs[0].x, vecs[0].c, 1'b0, 0, 0, lat, ovr_at, ovr_cnt, busy_low);
        check("post_rst_latency", 64'(lat), 64'(LAT));
        check("post_rst_sigOut", 64'(sigOut), 64'(vecs[0].y));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
